// File: rtl/bus_arbiter_rr.sv
// Round-robin bus arbiter for MASTER_NUM masters with active-low request/grant.
// Optional tenure limit (forced rotation) enabled by defining BUS_ARB_TENURE_EN.
module bus_arbiter_rr #(
    parameter int MASTER_NUM = 4,
    parameter int OWNER_W    = $clog2(MASTER_NUM),
    parameter int MAX_TENURE = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [MASTER_NUM-1:0] req_,
    output logic [MASTER_NUM-1:0] grnt_,
    output logic [OWNER_W-1:0]    owner,
    output logic                  tenure_expired
);

    if (MASTER_NUM < 2 || MASTER_NUM > 16 ||
        MAX_TENURE < 2 || MAX_TENURE > 256) begin : g_bad_cfg
        $error("bus_arbiter_rr: parameter out of range");
    end

    logic [OWNER_W-1:0] owner_q, owner_d;
    logic [OWNER_W:0]   sum;
    logic [OWNER_W-1:0] cand;
    logic               found;
    logic               own_req;
    logic               expired;

    assign own_req = ~req_[owner_q];

    // Nearest requester after the owner, wrapping; scanned far-to-near so
    // the closest one wins.
    always_comb begin
        found = 1'b0;
        cand  = owner_q;
        sum   = '0;
        for (int k = MASTER_NUM - 1; k >= 1; k--) begin
            sum = {1'b0, owner_q} + (OWNER_W + 1)'(k);
            if (sum >= (OWNER_W + 1)'(MASTER_NUM)) begin
                sum = sum - (OWNER_W + 1)'(MASTER_NUM);
            end
            if (!req_[sum[OWNER_W-1:0]]) begin
                found = 1'b1;
                cand  = sum[OWNER_W-1:0];
            end
        end
    end

    always_comb begin
        owner_d = owner_q;
        if ((!own_req || expired) && found) begin
            owner_d = cand;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            owner_q <= '0;
        end else begin
            owner_q <= owner_d;
        end
    end

    always_comb begin
        grnt_          = '1;
        grnt_[owner_q] = 1'b0;
    end

    assign owner = owner_q;

`ifdef BUS_ARB_TENURE_EN
    localparam int TCNT_W = $clog2(MAX_TENURE);
    localparam logic [TCNT_W-1:0] TCNT_MAX = TCNT_W'(MAX_TENURE - 1);

    logic [TCNT_W-1:0] tcnt_q, tcnt_d;
    logic              texp_q, texp_d;

    assign expired = own_req && (tcnt_q == TCNT_MAX) && found;

    always_comb begin
        tcnt_d = tcnt_q;
        texp_d = expired;
        if (owner_d != owner_q || !own_req) begin
            tcnt_d = '0;
        end else if (tcnt_q != TCNT_MAX) begin
            tcnt_d = tcnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tcnt_q <= '0;
            texp_q <= 1'b0;
        end else begin
            tcnt_q <= tcnt_d;
            texp_q <= texp_d;
        end
    end

    assign tenure_expired = texp_q;
`else
    assign expired        = 1'b0;
    assign tenure_expired = 1'b0;
`endif

endmodule

// File: tb/tb_bus_arbiter_rr.sv
// Self-checking bench for bus_arbiter_rr: directed scenarios plus random
// requests compared every cycle against a behavioural round-robin model.
module tb_bus_arbiter_rr;

    localparam int N   = 4;
    localparam int MT  = 8;
    localparam int OW  = $clog2(N);
`ifdef BUS_ARB_TENURE_EN
    localparam bit TEN = 1'b1;
`else
    localparam bit TEN = 1'b0;
`endif

    logic          clk;
    logic          reset;
    logic [N-1:0]  req_;
    logic [N-1:0]  grnt_;
    logic [OW-1:0] owner;
    logic          tenure_expired;

    int n_tests = 0;
    int n_fail  = 0;
    bit go      = 1'b0;

    int m_owner = 0;
    int m_held  = 0;
    bit m_texp  = 1'b0;

    bus_arbiter_rr #(
        .MASTER_NUM(N),
        .MAX_TENURE(MT)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .req_          (req_),
        .grnt_         (grnt_),
        .owner         (owner),
        .tenure_expired(tenure_expired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp,
                     $time);
        end
    endtask

    // Reference model: owner keeps the bus while requesting unless it has
    // completed MT requesting cycles and someone else waits; otherwise the
    // nearest requester after it (cyclically) takes over.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_owner = 0;
            m_held  = 0;
            m_texp  = 1'b0;
        end else begin
            bit own;
            bit exp_now;
            int other;
            own   = (req_[m_owner] == 1'b0);
            other = -1;
            for (int k = 1; k < N; k++) begin
                int c;
                c = (m_owner + k) % N;
                if (other < 0 && req_[c] == 1'b0) other = c;
            end
            exp_now = TEN && own && (m_held + 1 >= MT) && (other >= 0);
            if (own && !exp_now) begin
                m_held = m_held + 1;
                m_texp = 1'b0;
            end else if (other >= 0) begin
                m_owner = other;
                m_held  = 0;
                m_texp  = exp_now;
            end else begin
                m_held = 0;
                m_texp = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (go) begin
            logic [N-1:0] eg;
            eg          = '1;
            eg[m_owner] = 1'b0;
            chk("cyc_grnt", 32'(grnt_), 32'(eg));
            chk("cyc_owner", 32'(owner), 32'(m_owner));
            chk("cyc_texp", 32'(tenure_expired), 32'(m_texp));
        end
    end

    task automatic step(input logic [N-1:0] r);
        req_ = r;
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b0;
        req_  = '1;
        repeat (3) @(negedge clk);
        chk("rst_grnt", 32'(grnt_), 32'h0e);
        chk("rst_owner", 32'(owner), 32'h0);
        chk("rst_texp", 32'(tenure_expired), 32'h0);
        reset = 1'b1;
        go    = 1'b1;

        repeat (10) step(4'b1111);
        chk("idle_owner", 32'(owner), 32'h0);
        chk("idle_grnt", 32'(grnt_), 32'h0e);

        step(4'b0101);
        chk("rr_to1", 32'(owner), 32'h1);
        chk("rr_to1_grnt", 32'(grnt_), 32'h0d);
        step(4'b0111);
        chk("rr_to3", 32'(owner), 32'h3);
        step(4'b1101);
        chk("rr_wrap1", 32'(owner), 32'h1);

        step(4'b1011);
        chk("lone_to2", 32'(owner), 32'h2);
        for (int i = 0; i < 50; i++) begin
            step(4'b1011);
            chk("lone_hold", 32'(owner), 32'h2);
            chk("lone_texp", 32'(tenure_expired), 32'h0);
        end

        step(4'b1111);
        chk("park2", 32'(owner), 32'h2);
        repeat (7) step(4'b1010);
        chk("ten_pre", 32'(owner), 32'h2);
        step(4'b1010);
`ifdef BUS_ARB_TENURE_EN
        chk("ten_force", 32'(owner), 32'h0);
        chk("ten_pulse", 32'(tenure_expired), 32'h1);
        step(4'b1110);
        chk("ten_pulse_end", 32'(tenure_expired), 32'h0);
        chk("ten_keep0", 32'(owner), 32'h0);
`else
        chk("noten_keep", 32'(owner), 32'h2);
        chk("noten_texp", 32'(tenure_expired), 32'h0);
        step(4'b1110);
        chk("noten_rel", 32'(owner), 32'h0);
`endif

        step(4'b0111);
        chk("mid_to3", 32'(owner), 32'h3);
        repeat (5) step(4'b0111);
        #2 reset = 1'b0;
        #1;
        chk("async_grnt", 32'(grnt_), 32'h0e);
        chk("async_owner", 32'(owner), 32'h0);
        chk("async_texp", 32'(tenure_expired), 32'h0);
        @(negedge clk);
        reset = 1'b1;
        step(4'b0101);
        chk("resume_to1", 32'(owner), 32'h1);

        for (int i = 0; i < 3000; i++) begin
            logic [N-1:0] r;
            r = N'($urandom);
            if ($urandom_range(0, 3) == 0) r = r | N'($urandom);
            if ($urandom_range(0, 9) == 0) r = '1;
            if (i == 1500) begin
                #2 reset = 1'b0;
                @(negedge clk);
                reset = 1'b1;
            end
            step(r);
        end

        go = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/bus_arbiter_rr.md
# bus_arbiter_rr

Parametrised round-robin bus arbiter granting one of MASTER_NUM bus masters ownership of the shared bus. It is the successor of the fixed 4-master arbiter: master count is a parameter, an owner index is exported for the bus-side address/data multiplexers, and an optional tenure limit forces rotation when a master holds the bus too long while others wait. It sits between the master request/grant lines and the shared bus multiplexers.

## Interface
Parameters:
- MASTER_NUM, 4, number of masters; legal range 2..16.
- OWNER_W, $clog2(MASTER_NUM), width of owner index; derived, do not override.
- MAX_TENURE, 16, maximum consecutive granted-and-requesting cycles before forced rotation; legal range 2..256; used only with BUS_ARB_TENURE_EN.

Ports:
- clk  input  1  clock; all state on rising edge.
- reset  input  1  asynchronous, active-low reset.
- req_  input  MASTER_NUM  per-master bus request, active-low; bit i belongs to master i.
- grnt_  output  MASTER_NUM  per-master bus grant, active-low; exactly one bit low at all times.
- owner  output  OWNER_W  index of the current bus owner; drives the bus multiplexers.
- tenure_expired  output  1  high for one cycle when a forced rotation occurs; constant 0 without BUS_ARB_TENURE_EN.

## Operation
- State: owner register (OWNER_W bits); tenure counter tcnt ($clog2(MAX_TENURE) bits) when enabled.
- grnt_ decoded combinationally from owner: grnt_[owner]=0, all others 1. The bus always has an owner, even with no requests (parking).
- Next-owner rule, evaluated every cycle:
  - Owner request asserted and not expired: owner unchanged.
  - Otherwise: search cyclically from owner+1 upward, wrapping MASTER_NUM-1 -> 0; first master with req_ low becomes owner.
  - No master other than owner requesting: owner unchanged (parks on the last owner).
- Expired (enabled only): req_[owner]=0 and tcnt==MAX_TENURE-1 and at least one other req_ low.
- tcnt update:
  - Owner change: tcnt <= 0.
  - req_[owner]=1 (owner released): tcnt <= 0.
  - req_[owner]=0, no change: tcnt <= tcnt+1, saturating at MAX_TENURE-1. A lone requester keeps the bus indefinitely with tcnt saturated.
- tenure_expired registered: set the cycle after an edge at which rotation was caused by expiry, cleared otherwise.
- Requests of non-owners are never dropped; a waiting master is granted within (MASTER_NUM-1)×MAX_TENURE cycles when enabled.

## Timing
- Reset (reset low, asynchronous): owner=0, grnt_ = all ones except bit 0 = 0, tcnt=0, tenure_expired=0.
- First arbitration occurs at the first rising clk after reset deasserts.
- Request-to-grant latency: one cycle. req_ sampled at edge N; owner and grnt_ change after edge N; grnt_ has no combinational path from req_.
- Handover: old owner's grnt_ rises and new owner's grnt_ falls in the same cycle; no idle cycle, no overlap.
- Simultaneous requests: resolved purely by cyclic distance from current owner.
- Reset mid-tenure: owner forced to 0 immediately regardless of requests; counter cleared.

## Configuration
- BUS_ARB_TENURE_EN defined: tenure counter, expiry rotation and tenure_expired active as above.
- Not defined: no counter; owner keeps the bus as long as req_[owner] is low; tenure_expired tied to 0; MAX_TENURE ignored.

## Test plan
(MASTER_NUM=4, MAX_TENURE=8, BUS_ARB_TENURE_EN defined unless noted.)
- Reset with all req_=4'b1111 -> owner=0, grnt_=4'b1110; after 10 idle cycles still unchanged.
- Owner 0 releases, req_=4'b0101 (masters 1 and 3 requesting) -> owner=1 next cycle; master 1 releases -> owner=3; master 3 releases with only master 1 waiting -> owner=1 (wrap-around).
- Master 2 requests continuously and alone -> keeps grant for 50 cycles, tenure_expired stays 0.
- Master 2 owner, master 0 requests at cycle 0 while master 2 holds -> forced handover to master 0 after 8th granted cycle, tenure_expired pulses 1 cycle.
- Same stimulus without BUS_ARB_TENURE_EN -> master 2 keeps bus until req_[2]=1, then owner=0 next cycle.
- Assert reset while owner=3 and tcnt=5 -> grnt_=4'b1110 immediately without clock; after release arbitration resumes from owner 0.
